// File: rtl/csm_port_master_if.sv
// csm_port_master_if: processor request/response and manager port bundle.
// master = the sequencer, slave = processor plus manager side.
interface csm_port_master_if #(
  parameter int DATABITS  = 8,
  parameter int MEMSIZE   = 8,
  parameter int MAX_RETRY = 3,
  parameter int ADDRBITS  = $clog2(MEMSIZE),
  parameter int RETBITS   = $clog2(MAX_RETRY + 1)
);
  logic                req_valid;
  logic                req_ready;
  logic [1:0]          req_op;
  logic [ADDRBITS-1:0] req_addr;
  logic [DATABITS-1:0] req_wdata;
  logic                rsp_valid;
  logic [DATABITS-1:0] rsp_rdata;
  logic [1:0]          rsp_err;
  logic [RETBITS-1:0]  rsp_retries;
  logic                held;
  logic [DATABITS-1:0] csm_ad;
  logic                csm_rw;
  logic                csm_enable;
  logic                csm_hold;
  logic                csm_release;
  logic [DATABITS-1:0] csm_out_data;
  logic [1:0]          csm_err;
  logic                csm_ack;

  modport master (
    input  req_valid, req_op, req_addr, req_wdata,
    input  csm_out_data, csm_err, csm_ack,
    output req_ready, rsp_valid, rsp_rdata,
    output rsp_err, rsp_retries, held,
    output csm_ad, csm_rw, csm_enable,
    output csm_hold, csm_release
  );

  modport slave (
    output req_valid, req_op, req_addr, req_wdata,
    output csm_out_data, csm_err, csm_ack,
    input  req_ready, rsp_valid, rsp_rdata,
    input  rsp_err, rsp_retries, held,
    input  csm_ad, csm_rw, csm_enable,
    input  csm_hold, csm_release
  );
endinterface

// File: rtl/csm_port_master.sv
// csm_port_master: sequences processor requests onto one manager port,
// retrying refused attempts after a fixed backoff.
module csm_port_master #(
  parameter int DATABITS  = 8,
  parameter int MEMSIZE   = 8,
  parameter int MAX_RETRY = 3,
  parameter int BACKOFF   = 2
) (
  input  logic clk,
  input  logic reset_n,
  csm_port_master_if.master bus
);
  localparam int ADDRBITS = $clog2(MEMSIZE);
  localparam int RETBITS  = $clog2(MAX_RETRY + 1);
  localparam int BOBITS   = $clog2(BACKOFF + 1);

  localparam logic [1:0] OP_RD  = 2'b00;
  localparam logic [1:0] OP_WR  = 2'b01;
  localparam logic [1:0] OP_HLD = 2'b10;
  localparam logic [1:0] OP_REL = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_DATA, S_CTRL, S_BOFF, S_RESP
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [1:0]          r_op;
  logic [ADDRBITS-1:0] r_addr;
  logic [DATABITS-1:0] r_wdata;
  logic [RETBITS-1:0]  r_retry;
  logic [BOBITS-1:0]   r_bo;
  logic                r_held;
  logic [DATABITS-1:0] r_rsp_rdata;
  logic [1:0]          r_rsp_err;
  logic [RETBITS-1:0]  r_rsp_retries;

  logic w_ok;
  logic w_can_retry;
  logic w_skip;
  logic w_bo_done;

  assign w_ok        = (bus.csm_err == 2'b00) && bus.csm_ack;
  assign w_can_retry = r_retry < RETBITS'(MAX_RETRY);
  assign w_skip      = (r_op == OP_REL) && !r_held;
  assign w_bo_done   = r_bo == BOBITS'(BACKOFF - 1);

  // state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // next-state decode
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (bus.req_valid)
          w_next = bus.req_op[1] ? S_CTRL : S_ADDR;
      end
      S_ADDR: begin
        if (w_ok)             w_next = S_DATA;
        else if (w_can_retry) w_next = S_BOFF;
        else                  w_next = S_RESP;
      end
      S_DATA: w_next = S_RESP;
      S_CTRL: begin
        if (w_skip || w_ok)   w_next = S_RESP;
        else if (w_can_retry) w_next = S_BOFF;
        else                  w_next = S_RESP;
      end
      S_BOFF: begin
        if (w_bo_done)
          w_next = r_op[1] ? S_CTRL : S_ADDR;
      end
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // request latch, retry/backoff counters, lock flag, response registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_op          <= '0;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_retry       <= '0;
      r_bo          <= '0;
      r_held        <= 1'b0;
      r_rsp_rdata   <= '0;
      r_rsp_err     <= '0;
      r_rsp_retries <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (bus.req_valid) begin
            r_op    <= bus.req_op;
            r_addr  <= bus.req_addr;
            r_wdata <= bus.req_wdata;
            r_retry <= '0;
          end
        end
        S_ADDR, S_CTRL: begin
          if (r_state == S_CTRL && w_skip) begin
            r_rsp_err     <= 2'b01;
            r_rsp_retries <= '0;
            r_rsp_rdata   <= '0;
          end else if (w_ok) begin
            if (r_state == S_CTRL) begin
              r_held        <= (r_op == OP_HLD);
              r_rsp_err     <= 2'b00;
              r_rsp_retries <= r_retry;
              r_rsp_rdata   <= '0;
            end
          end else if (w_can_retry) begin
            r_retry <= r_retry + RETBITS'(1);
            r_bo    <= '0;
          end else begin
            r_rsp_err     <= bus.csm_err;
            r_rsp_retries <= r_retry;
            r_rsp_rdata   <= '0;
          end
        end
        S_DATA: begin
          r_rsp_err     <= 2'b00;
          r_rsp_retries <= r_retry;
          r_rsp_rdata   <= (r_op == OP_RD) ? bus.csm_out_data : '0;
        end
        S_BOFF:  r_bo <= r_bo + BOBITS'(1);
        default: ;
      endcase
    end
  end

  // port drive and handshake outputs from the current state
  always_comb begin
    bus.req_ready   = (r_state == S_IDLE) && reset_n;
    bus.rsp_valid   = 1'b0;
    bus.csm_ad      = '0;
    bus.csm_rw      = 1'b0;
    bus.csm_enable  = 1'b0;
    bus.csm_hold    = r_held;
    bus.csm_release = 1'b0;
    unique case (r_state)
      S_ADDR: begin
        bus.csm_enable = 1'b1;
        bus.csm_rw     = (r_op == OP_WR);
        bus.csm_ad     = DATABITS'(r_addr);
      end
      S_DATA: begin
        bus.csm_rw = (r_op == OP_WR);
        bus.csm_ad = (r_op == OP_WR) ? r_wdata : '0;
      end
      S_CTRL: begin
        if (r_op == OP_HLD) begin
          bus.csm_hold = 1'b1;
        end else if (r_held) begin
          bus.csm_hold    = 1'b0;
          bus.csm_release = 1'b1;
        end
      end
      S_RESP:  bus.rsp_valid = 1'b1;
      default: ;
    endcase
  end

  assign bus.rsp_rdata   = r_rsp_rdata;
  assign bus.rsp_err     = r_rsp_err;
  assign bus.rsp_retries = r_rsp_retries;
  assign bus.held        = r_held;

endmodule

// File: tb/tb_csm_port_master.sv
// tb_csm_port_master: random transactions against a cycle-schedule
// reference model with a behavioural manager register file.
module tb_csm_port_master;
  localparam int DB = 8;
  localparam int MS = 8;
  localparam int MR = 3;
  localparam int BO = 2;
  localparam int AB = 3;
  localparam int RB = 2;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  csm_port_master_if #(
    .DATABITS(DB), .MEMSIZE(MS), .MAX_RETRY(MR)
  ) bus ();

  csm_port_master #(
    .DATABITS(DB), .MEMSIZE(MS),
    .MAX_RETRY(MR), .BACKOFF(BO)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  int n_chk = 0;
  int n_fail = 0;

  logic [DB-1:0] mem [MS];
  logic          held_m;
  logic [DB-1:0] last_rd;
  logic [1:0]    last_err;
  logic [RB-1:0] last_ret;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)",
               tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] strb();
    return {20'b0, bus.csm_enable, bus.csm_rw,
            bus.csm_release, bus.csm_hold, bus.csm_ad};
  endfunction

  function automatic logic [31:0] es(bit en, bit rw, bit rel,
                                     bit hd, logic [DB-1:0] ad);
    return {20'b0, en, rw, rel, hd, ad};
  endfunction

  function automatic logic [31:0] all_outs();
    return 32'({bus.req_ready, bus.rsp_valid, bus.rsp_rdata,
                bus.rsp_err, bus.rsp_retries, bus.held,
                bus.csm_ad, bus.csm_rw, bus.csm_enable,
                bus.csm_hold, bus.csm_release});
  endfunction

  // one request; nref = refusals before success (>MR means give up);
  // rst_at = cycle offset at which reset is asserted, -1 for none
  task automatic txn(input logic [1:0] op, input logic [AB-1:0] a,
                     input logic [DB-1:0] wd, input int nref,
                     input logic [1:0] code, input int rst_at);
    int att, per, L, tend, j;
    bit ok, rw_op, skip;
    logic [1:0] lerr;
    logic [31:0] exp;
    logic [DB-1:0] erd;
    logic [1:0] eerr;
    logic [RB-1:0] eret;
    rw_op = !op[1];
    skip  = (op == 2'b11) && !held_m;
    ok    = nref <= MR;
    att   = ok ? nref + 1 : MR + 1;
    per   = 1 + BO;
    L     = 1 + (att - 1) * per;
    if (skip)            tend = 2;
    else if (ok && rw_op) tend = L + 2;
    else                 tend = L + 1;
    lerr = 2'b00;

    chk("idle_ready", 32'(bus.req_ready), 1);
    chk("idle_rspv", 32'(bus.rsp_valid), 0);
    chk("rsp_kept", 32'({bus.rsp_err, bus.rsp_retries, bus.rsp_rdata}),
        32'({last_err, last_ret, last_rd}));
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_addr  = a;
    bus.req_wdata = wd;
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_op    = 2'($urandom);
    bus.req_addr  = AB'($urandom);
    bus.req_wdata = DB'($urandom);

    for (int t = 1; t <= tend; t++) begin
      bus.csm_err      = 2'($urandom);
      bus.csm_ack      = 1'($urandom);
      bus.csm_out_data = DB'($urandom);
      if (t == tend) begin
        if (!skip && ok && op == 2'b10) held_m = 1'b1;
        if (!skip && ok && op == 2'b11) held_m = 1'b0;
        erd  = (ok && !skip && op == 2'b00) ? mem[a] : '0;
        eerr = skip ? 2'b01 : (ok ? 2'b00 : lerr);
        eret = skip ? '0 : RB'(att - 1);
        chk("rsp_valid", 32'(bus.rsp_valid), 1);
        chk("rsp_rdata", 32'(bus.rsp_rdata), 32'(erd));
        chk("rsp_err", 32'(bus.rsp_err), 32'(eerr));
        chk("rsp_retries", 32'(bus.rsp_retries), 32'(eret));
        chk("rsp_held", 32'(bus.held), 32'(held_m));
        chk("rsp_ready", 32'(bus.req_ready), 0);
        chk("rsp_strobes", strb(), es(0, 0, 0, held_m, '0));
        if (ok && op == 2'b01) mem[a] = wd;
        last_rd  = erd;
        last_err = eerr;
        last_ret = eret;
      end else begin
        chk("busy_rspv", 32'(bus.rsp_valid), 0);
        chk("busy_ready", 32'(bus.req_ready), 0);
        chk("busy_held", 32'(bus.held), 32'(held_m));
        if (skip) begin
          exp = es(0, 0, 0, 0, '0);
        end else if (t <= L && (t - 1) % per == 0) begin
          j = (t - 1) / per;
          if (rw_op)            exp = es(1, op == 2'b01, 0, held_m, DB'(a));
          else if (op == 2'b10) exp = es(0, 0, 0, 1, '0);
          else                  exp = es(0, 0, 1, 0, '0);
          if (j < nref) begin
            bus.csm_err = code;
            bus.csm_ack = (code == 2'b00) ? 1'b0 : 1'($urandom);
            lerr = code;
          end else begin
            bus.csm_err = 2'b00;
            bus.csm_ack = 1'b1;
          end
        end else if (t <= L) begin
          exp = es(0, 0, 0, held_m, '0);
        end else begin
          exp = es(0, op == 2'b01, 0, held_m, op == 2'b01 ? wd : '0);
          bus.csm_out_data = mem[a];
        end
        chk("strobes", strb(), exp);
        if (t == rst_at) begin
          #2 reset_n = 1'b0;
          #1 chk("rst_outs", all_outs(), 0);
          held_m   = 1'b0;
          last_rd  = '0;
          last_err = '0;
          last_ret = '0;
          @(negedge clk);
          chk("rst_hold_outs", all_outs(), 0);
          @(negedge clk);
          reset_n = 1'b1;
          #1;
          chk("post_rst_ready", 32'(bus.req_ready), 1);
          chk("post_rst_held", 32'(bus.held), 0);
          chk("post_rst_rspv", 32'(bus.rsp_valid), 0);
          @(negedge clk);
          return;
        end
      end
      @(negedge clk);
    end
  endtask

  initial begin
    int nref;
    reset_n          = 1'b0;
    bus.req_valid    = 1'b0;
    bus.req_op       = '0;
    bus.req_addr     = '0;
    bus.req_wdata    = '0;
    bus.csm_out_data = '0;
    bus.csm_err      = '0;
    bus.csm_ack      = 1'b0;
    for (int i = 0; i < MS; i++) mem[i] = '0;
    held_m   = 1'b0;
    last_rd  = '0;
    last_err = '0;
    last_ret = '0;
    #1 chk("reset_outs", all_outs(), 0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    txn(2'b01, 3'd3, 8'hA5, 0, 2'b00, -1);
    txn(2'b00, 3'd3, 8'h00, 0, 2'b00, -1);
    txn(2'b01, 3'd5, 8'h3C, 2, 2'b01, -1);
    txn(2'b00, 3'd5, 8'h00, 1, 2'b00, -1);
    txn(2'b01, 3'd6, 8'h77, MR + 1, 2'b10, -1);
    txn(2'b00, 3'd6, 8'h00, 0, 2'b00, -1);
    txn(2'b10, 3'd0, 8'h00, 0, 2'b00, -1);
    txn(2'b00, 3'd3, 8'h00, 0, 2'b00, -1);
    txn(2'b11, 3'd0, 8'h00, 0, 2'b00, -1);
    txn(2'b11, 3'd0, 8'h00, 0, 2'b00, -1);
    txn(2'b10, 3'd0, 8'h00, 1, 2'b11, -1);
    txn(2'b10, 3'd0, 8'h00, 0, 2'b00, -1);
    txn(2'b11, 3'd0, 8'h00, MR + 1, 2'b01, -1);
    txn(2'b01, 3'd2, 8'h11, 1, 2'b01, 2);
    txn(2'b11, 3'd0, 8'h00, 0, 2'b00, -1);

    for (int k = 0; k < 80; k++) begin
      nref = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, MR + 1);
      txn(2'($urandom), AB'($urandom), DB'($urandom),
          nref, 2'($urandom), -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/csm_port_master.md
# csm_port_master

Processor-side port sequencer that sits directly upstream of one port (A or B) of the critical section manager. It accepts single transactions from a processor over a valid/ready request interface. It sequences each transaction onto the manager's multiplexed address/data, enable, rw, hold and release strobes, then samples the manager's err/ack. It retries refused transactions with a fixed backoff and returns read data and final status as a one-cycle response pulse.

## Interface
- DATABITS, 8, width of manager AD bus and data
- MEMSIZE, 8, number of manager registers; ADDRBITS = $clog2(MEMSIZE)
- MAX_RETRY, 3, retries after the first attempt before giving up
- BACKOFF, 2, idle cycles between a refused attempt and its retry (≥1)
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when high with req_valid
- req_op  in  2  00 READ, 01 WRITE, 10 HOLD, 11 RELEASE
- req_addr  in  ADDRBITS  register index
- req_wdata  in  DATABITS  write data
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  DATABITS  read data; valid with rsp_valid on READ, else 0
- rsp_err  out  2  final manager error code (00 none, 01 in use, 10 dual write, 11 dual hold)
- rsp_retries  out  $clog2(MAX_RETRY+1)  retries consumed
- held  out  1  this port currently owns the manager lock
- csm_ad, csm_rw, csm_enable, csm_hold, csm_release  out  DATABITS/1/1/1/1  manager port drive
- csm_out_data  in  DATABITS  manager read data
- csm_err  in  2  manager error code
- csm_ack  in  1  manager acknowledge

## Operation
- States: IDLE, ADDR, DATA, CTRL, BACKOFF, RESP.
- IDLE: req_ready=1. On req_valid, latch op/addr/wdata, clear the retry counter, and go to CTRL for HOLD/RELEASE, else ADDR.
- RELEASE with held=0 skips the manager: go to RESP with rsp_err=01, rsp_retries=0.
- ADDR: csm_enable=1, csm_rw=(op==WRITE), csm_ad=addr zero-extended. Sample csm_err/csm_ack at the end of the cycle.
  - err==00 and ack==1: go to DATA.
  - Otherwise, if retries<MAX_RETRY: increment retries and go to BACKOFF.
  - Otherwise: go to RESP with rsp_err=csm_err.
- DATA: csm_enable=0, csm_rw=(op==WRITE), csm_ad=wdata for WRITE and 0 for READ. For READ, capture csm_out_data at the end of the cycle. Always go to RESP with rsp_err=00.
- CTRL, HOLD op: csm_hold=1. RELEASE op: csm_hold=0 and csm_release=1. Sample err/ack; retry and failure rules are the same as ADDR. On success, HOLD sets held and RELEASE clears held.
- BACKOFF: all strobes low except the standing hold. Count BACKOFF cycles, then return to ADDR or CTRL according to op.
- RESP: rsp_valid=1 with rdata, err and retries. Next state is IDLE.
- Standing hold: while held=1, csm_hold=1 in every state except CTRL-RELEASE.
- A HOLD request while already held completes through CTRL normally; held stays 1.
- rsp_rdata, rsp_err and rsp_retries are registered. They hold their values after RESP until the next RESP, and read 0 when not valid only after reset.

## Timing
- Reset (async assert, sync deassert use): state IDLE, held=0. All outputs 0, including req_ready while reset_n is low.
- Reset mid-transaction abandons it with no rsp_valid, and drops any standing hold immediately.
- READ/WRITE, no refusal: accept edge T. ADDR in T+1, DATA in T+2, rsp_valid in T+3. Next accept is possible at T+4.
- HOLD/RELEASE, no refusal: CTRL in T+1, rsp_valid in T+2.
- Each refusal adds 1+BACKOFF cycles. Worst-case READ/WRITE latency is 3+MAX_RETRY·(1+BACKOFF) cycles.
- req_ready is combinational from state only. It never depends on req_valid.
- csm_err/csm_ack are sampled only at the end of ADDR or CTRL. Their values in other states are ignored.

## Test plan
- Clean write then read: WRITE addr 3 data 0xA5 gives csm_enable in T+1 with csm_ad=0x03, csm_ad=0xA5 in T+2, and rsp_valid T+3 with err 00. The following READ addr 3 returns rsp_rdata=0xA5, retries 0.
- Retry then succeed: force csm_err=01/ack=0 on the first two ADDR samples, then 00/1. Require exactly two BACKOFF windows of BACKOFF cycles with strobes low, and rsp_err=00, rsp_retries=2.
- Retry exhaustion: csm_err=10 on every attempt gives MAX_RETRY+1 ADDR cycles, then rsp_err=10, rsp_retries=3, and no DATA cycle.
- Lock lifecycle: HOLD succeeds, so held=1 and csm_hold stays high across a following READ. RELEASE pulses csm_release with csm_hold low, then held=0. A second RELEASE returns rsp_err=01 in T+2 without touching csm_* strobes.
- Reset mid-operation: drop reset_n during the BACKOFF of a held-port WRITE. All outputs go 0 immediately, held=0, no rsp_valid, and req_ready=1 on the first cycle after reset deasserts.
